// File: rtl/rst_n_seq.sv
// rst_n_seq: staggered reset release sequencer with optional sticky cause (RST_N_SEQ_CAUSE_EN)
module rst_n_seq #(
   parameter int NUM_DOMAINS    = 3,
   parameter int NUM_REQ        = 2,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   async_rst_n,
   input  logic [NUM_REQ-1:0]     rst_req,
   input  logic                   cause_clr,
   output logic [NUM_DOMAINS-1:0] sync_rst_n,
   output logic                   busy,
   output logic [NUM_REQ:0]       cause
);
   localparam logic [1:0] ASSERT  = 2'd0;
   localparam logic [1:0] RELEASE = 2'd1;
   localparam logic [1:0] RUN     = 2'd2;
   logic [1:0]  state;
   logic [15:0] cnt;
   logic [3:0]  idx;
   logic        req_any;
   assign req_any = |rst_req;
   assign busy = ~&sync_rst_n;
   // hold all domains low for HOLD_CYCLES quiet cycles, then release them one by one in ascending order
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         state      <= ASSERT;
         cnt        <= '0;
         idx        <= '0;
         sync_rst_n <= '0;
      end else if (state != ASSERT && req_any) begin
         state      <= ASSERT;
         cnt        <= '0;
         idx        <= '0;
         sync_rst_n <= '0;
      end else if (state == ASSERT) begin
         if (req_any) cnt <= '0;
         else if (cnt == 16'(HOLD_CYCLES - 1)) begin
            state      <= (NUM_DOMAINS == 1) ? RUN : RELEASE;
            cnt        <= '0;
            idx        <= 4'd1;
            sync_rst_n <= NUM_DOMAINS'(1);
         end else cnt <= cnt + 16'd1;
      end else if (state == RELEASE) begin
         if (cnt == 16'(STAGGER_CYCLES - 1)) begin
            sync_rst_n <= NUM_DOMAINS'({sync_rst_n, 1'b1});
            cnt        <= '0;
            idx        <= idx + 4'd1;
            if (idx == 4'(NUM_DOMAINS - 1)) state <= RUN;
         end else cnt <= cnt + 16'd1;
      end
   end
`ifdef RST_N_SEQ_CAUSE_EN
   // sticky cause: power-on sets bit0, each request sets its bit; a set beats a simultaneous clear
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) cause <= (NUM_REQ + 1)'(1);
      else cause <= (cause_clr ? '0 : cause) | {rst_req, 1'b0};
   end
`else
   logic unused_cause_clr;
   assign unused_cause_clr = cause_clr;
   assign cause = '0;
`endif
endmodule
